// File: rtl/dtmf_sequencer.sv
// DTMF digit sequencer: latches a keypad digit list on play and steps through
// it, presenting row/column phase increments to the tone synthesiser with an
// optional silent gap between digits. One clock cycle is one PCM sample.
module dtmf_sequencer #(
    parameter int NUM_DIGITS   = 8,
    parameter int SAMPLE_RATE  = 80000,
    parameter int TONE_SAMPLES = 8000,
    parameter int GAP_SAMPLES  = 800,
    parameter int PINC_WIDTH   = 16
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     play,
    input  logic [4*NUM_DIGITS-1:0]                                  digits,
    output logic [PINC_WIDTH-1:0]                                    row_inc,
    output logic [PINC_WIDTH-1:0]                                    col_inc,
    output logic                                                     tone_en,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0]  digit_idx,
    output logic                                                     busy,
    output logic                                                     done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (TONE_SAMPLES > GAP_SAMPLES) ? TONE_SAMPLES : GAP_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_SAMPLES > 0) ? (GAP_SAMPLES - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Rounded phase increment for a tone frequency: (f * 2^W + SR/2) / SR.
    function automatic logic [63:0] calc_inc(input logic [63:0] f_hz);
        logic [63:0] sr;
        sr = 64'(SAMPLE_RATE);
        return (f_hz * (64'd1 << PINC_WIDTH) + (sr >> 1)) / sr;
    endfunction

    localparam logic [PINC_WIDTH-1:0] ROW0 = PINC_WIDTH'(calc_inc(64'd697));
    localparam logic [PINC_WIDTH-1:0] ROW1 = PINC_WIDTH'(calc_inc(64'd770));
    localparam logic [PINC_WIDTH-1:0] ROW2 = PINC_WIDTH'(calc_inc(64'd852));
    localparam logic [PINC_WIDTH-1:0] ROW3 = PINC_WIDTH'(calc_inc(64'd941));
    localparam logic [PINC_WIDTH-1:0] COL0 = PINC_WIDTH'(calc_inc(64'd1209));
    localparam logic [PINC_WIDTH-1:0] COL1 = PINC_WIDTH'(calc_inc(64'd1336));
    localparam logic [PINC_WIDTH-1:0] COL2 = PINC_WIDTH'(calc_inc(64'd1477));
    localparam logic [PINC_WIDTH-1:0] COL3 = PINC_WIDTH'(calc_inc(64'd1633));

    // Row tone of a key code (0-9, A-D = 10-13, '*' = 14, '#' = 15).
    function automatic logic [PINC_WIDTH-1:0] row_of(input logic [3:0] code);
        case (code)
            4'd1, 4'd2, 4'd3, 4'd10:   return ROW0;
            4'd4, 4'd5, 4'd6, 4'd11:   return ROW1;
            4'd7, 4'd8, 4'd9, 4'd12:   return ROW2;
            4'd14, 4'd0, 4'd15, 4'd13: return ROW3;
            default:                   return {PINC_WIDTH{1'b0}};
        endcase
    endfunction

    // Column tone of a key code.
    function automatic logic [PINC_WIDTH-1:0] col_of(input logic [3:0] code);
        case (code)
            4'd1, 4'd4, 4'd7, 4'd14:   return COL0;
            4'd2, 4'd5, 4'd8, 4'd0:    return COL1;
            4'd3, 4'd6, 4'd9, 4'd15:   return COL2;
            4'd10, 4'd11, 4'd12, 4'd13: return COL3;
            default:                   return {PINC_WIDTH{1'b0}};
        endcase
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [PINC_WIDTH-1:0]   row_q;
    logic [PINC_WIDTH-1:0]   col_q;
    logic                    tone_q;
    logic                    busy_q;
    logic                    done_q;

    logic [IDX_W-1:0]        nxt_idx_d;
    logic [3:0]              nxt_code_d;

    // Select the latched code of the digit that follows the current one.
    always_comb begin
        nxt_idx_d  = idx_q + IDX_W'(1);
        nxt_code_d = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nxt_code_d = (nxt_idx_d == IDX_W'(i)) ? digits_q[4*i +: 4] : nxt_code_d;
        end
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            digits_q <= {(4*NUM_DIGITS){1'b0}};
            row_q    <= {PINC_WIDTH{1'b0}};
            col_q    <= {PINC_WIDTH{1'b0}};
            tone_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q  <= {CNT_W{1'b0}};
                    idx_q  <= {IDX_W{1'b0}};
                    done_q <= 1'b0;
                    if (play) begin
                        state_q  <= ST_TONE;
                        digits_q <= digits;
                        row_q    <= row_of(digits[3:0]);
                        col_q    <= col_of(digits[3:0]);
                        tone_q   <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        row_q  <= {PINC_WIDTH{1'b0}};
                        col_q  <= {PINC_WIDTH{1'b0}};
                        tone_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                ST_TONE: begin
                    if (!play) begin
                        // Abort: silence immediately, no done pulse.
                        state_q <= ST_IDLE;
                        cnt_q   <= {CNT_W{1'b0}};
                        idx_q   <= {IDX_W{1'b0}};
                        row_q   <= {PINC_WIDTH{1'b0}};
                        col_q   <= {PINC_WIDTH{1'b0}};
                        tone_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (cnt_q == TONE_LAST) begin
                        cnt_q <= {CNT_W{1'b0}};
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_DONE;
                            idx_q   <= {IDX_W{1'b0}};
                            row_q   <= {PINC_WIDTH{1'b0}};
                            col_q   <= {PINC_WIDTH{1'b0}};
                            tone_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (GAP_SAMPLES > 0) begin
                            state_q <= ST_GAP;
                            row_q   <= {PINC_WIDTH{1'b0}};
                            col_q   <= {PINC_WIDTH{1'b0}};
                            tone_q  <= 1'b0;
                        end else begin
                            // Back-to-back tones: next digit loads on this edge.
                            idx_q <= nxt_idx_d;
                            row_q <= row_of(nxt_code_d);
                            col_q <= col_of(nxt_code_d);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (!play) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= {CNT_W{1'b0}};
                        idx_q   <= {IDX_W{1'b0}};
                        row_q   <= {PINC_WIDTH{1'b0}};
                        col_q   <= {PINC_WIDTH{1'b0}};
                        tone_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (cnt_q == GAP_LAST) begin
                        state_q <= ST_TONE;
                        cnt_q   <= {CNT_W{1'b0}};
                        idx_q   <= nxt_idx_d;
                        row_q   <= row_of(nxt_code_d);
                        col_q   <= col_of(nxt_code_d);
                        tone_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // done is a single-cycle pulse; wait for play to drop.
                    done_q <= 1'b0;
                    cnt_q  <= {CNT_W{1'b0}};
                    if (!play) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                    idx_q   <= {IDX_W{1'b0}};
                    row_q   <= {PINC_WIDTH{1'b0}};
                    col_q   <= {PINC_WIDTH{1'b0}};
                    tone_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign row_inc   = row_q;
    assign col_inc   = col_q;
    assign tone_en   = tone_q;
    assign digit_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dtmf_sequencer.sv
// Self-checking bench for dtmf_sequencer: directed scenarios plus randomized
// digit lists, checked against a keypad/frequency reference model.
module tb_dtmf_sequencer;

    logic        clk;
    logic        rst;
    logic        play;
    logic [11:0] digits;
    logic [15:0] row_inc, col_inc;
    logic        tone_en, busy, done;
    logic [1:0]  digit_idx;

    logic        play2;
    logic [7:0]  digits2;
    logic [15:0] row_inc2, col_inc2;
    logic        tone_en2, busy2, done2;
    logic [0:0]  digit_idx2;

    dtmf_sequencer #(
        .NUM_DIGITS(3), .SAMPLE_RATE(80000), .TONE_SAMPLES(4),
        .GAP_SAMPLES(2), .PINC_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .play(play), .digits(digits),
        .row_inc(row_inc), .col_inc(col_inc), .tone_en(tone_en),
        .digit_idx(digit_idx), .busy(busy), .done(done)
    );

    dtmf_sequencer #(
        .NUM_DIGITS(2), .SAMPLE_RATE(80000), .TONE_SAMPLES(4),
        .GAP_SAMPLES(0), .PINC_WIDTH(16)
    ) dut_ng (
        .clk(clk), .rst(rst), .play(play2), .digits(digits2),
        .row_inc(row_inc2), .col_inc(col_inc2), .tone_en(tone_en2),
        .digit_idx(digit_idx2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
        logic        tone;
        logic [1:0]  idx;
        logic        busy;
        logic        done;
    } obs_t;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q[$];
    obs_t zero_o = '0;

    int row_hz[4] = '{697, 770, 852, 941};
    int col_hz[4] = '{1209, 1336, 1477, 1633};
    int keymap[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    function automatic logic [15:0] inc_of(input int f);
        longint v;
        v = (longint'(f) * 65536 + 40000) / 80000;
        return v[15:0];
    endfunction

    // Expected output word while digit `code` at position `idx` is sounding.
    function automatic obs_t tone_obs(input int code, input int idx);
        obs_t o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keymap[r][c] == code) begin
                    o.row = inc_of(row_hz[r]);
                    o.col = inc_of(col_hz[c]);
                end
        o.tone = 1'b1;
        o.idx  = 2'(idx);
        o.busy = 1'b1;
        return o;
    endfunction

    // Expected per-cycle output stream of one full sequence, ending with done.
    task automatic build(input logic [31:0] dl, input int n, input int tone, input int gap);
        obs_t g;
        exp_q.delete();
        for (int d = 0; d < n; d++) begin
            for (int t = 0; t < tone; t++) exp_q.push_back(tone_obs(int'((dl >> (4*d)) & 32'hF), d));
            if (d < n - 1) begin
                g = '0;
                g.idx  = 2'(d);
                g.busy = 1'b1;
                for (int t = 0; t < gap; t++) exp_q.push_back(g);
            end
        end
        g = '0;
        g.done = 1'b1;
        exp_q.push_back(g);
    endtask

    function automatic obs_t exp_at(input int k);
        if (k < exp_q.size()) return exp_q[k];
        return '0;
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o.row = row_inc; o.col = col_inc; o.tone = tone_en;
        o.idx = digit_idx; o.busy = busy; o.done = done;
        return o;
    endfunction

    function automatic obs_t obs2();
        obs_t o;
        o.row = row_inc2; o.col = col_inc2; o.tone = tone_en2;
        o.idx = {1'b0, digit_idx2}; o.busy = busy2; o.done = done2;
        return o;
    endfunction

    task automatic chk(input string tag, input int cyc, input obs_t o, input obs_t e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s cyc%0d: got row=%0d col=%0d tone=%0b idx=%0d busy=%0b done=%0b, expected row=%0d col=%0d tone=%0b idx=%0d busy=%0b done=%0b",
                   tag, cyc, o.row, o.col, o.tone, o.idx, o.busy, o.done,
                   e.row, e.col, e.tone, e.idx, e.busy, e.done);
        end
    endtask

    // One play session on the gapped DUT; optional abort and digit-bus glitch.
    task automatic run_seq(input string tag, input logic [11:0] dl, input int ncyc,
                           input int abort_at, input int glitch_at);
        bit aborted;
        aborted = 1'b0;
        build({20'd0, dl}, 3, 4, 2);
        @(negedge clk);
        digits = dl;
        play   = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            chk(tag, k, obs1(), aborted ? zero_o : exp_at(k - 1));
            if (k == glitch_at) digits = 12'(~dl);
            if (k == abort_at) begin
                play    = 1'b0;
                aborted = 1'b1;
            end
        end
        play = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, ncyc + 1, obs1(), zero_o);
    endtask

    logic [11:0] basic_dl;
    logic [11:0] rnd_dl;
    logic [7:0]  rnd2;
    obs_t        e;
    int          ng_row[9] = '{771, 771, 771, 771, 771, 771, 771, 771, 0};
    int          ng_col[9] = '{1338, 1338, 1338, 1338, 990, 990, 990, 990, 0};

    initial begin
        basic_dl = {4'd15, 4'd5, 4'd1};
        rst = 1'b1; play = 1'b0; digits = 12'd0; play2 = 1'b0; digits2 = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset", 0, obs1(), zero_o);
        chk("reset_ng", 0, obs2(), zero_o);
        rst = 1'b0;
        @(negedge clk);
        chk("idle", 0, obs1(), zero_o);

        // Basic sequence with play held well beyond done, then re-arm.
        run_seq("basic", basic_dl, 20, 0, 0);
        run_seq("rearm", basic_dl, 18, 0, 0);

        // Abort during the second tone.
        run_seq("abort", basic_dl, 14, 8, 0);

        // Digit bus changes while busy must not affect playback.
        run_seq("isolate", basic_dl, 18, 0, 2);

        // Asynchronous reset mid-tone, play kept high across it.
        build({20'd0, basic_dl}, 3, 4, 2);
        @(negedge clk);
        digits = basic_dl;
        play   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("prerst", k, obs1(), exp_at(k - 1));
        end
        #1 rst = 1'b1;
        #1 chk("rst_async", 3, obs1(), zero_o);
        #1 rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("postrst", k, obs1(), exp_at(k - 1));
        end
        play = 1'b0;
        @(negedge clk);
        chk("postrst_idle", 18, obs1(), zero_o);

        // Randomized digit lists, aborts and glitches.
        for (int r = 0; r < 8; r++) begin
            rnd_dl = 12'($urandom);
            run_seq("rand", rnd_dl, 19,
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 18)),
                    int'($urandom_range(0, 16)));
        end

        // No-gap instance: {*,D} against literal increments.
        @(negedge clk);
        digits2 = {4'd14, 4'd13};
        play2   = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            e = '0;
            if (k <= 9) begin
                e.row = 16'(ng_row[k-1]);
                e.col = 16'(ng_col[k-1]);
            end
            if (k <= 8) begin
                e.tone = 1'b1;
                e.busy = 1'b1;
                e.idx  = (k > 4) ? 2'd1 : 2'd0;
            end
            if (k == 9) e.done = 1'b1;
            chk("nogap", k, obs2(), e);
        end
        play2 = 1'b0;
        @(negedge clk);
        chk("nogap_idle", 12, obs2(), zero_o);

        // No-gap instance with random digits against the model.
        for (int r = 0; r < 3; r++) begin
            rnd2 = 8'($urandom);
            build({24'd0, rnd2}, 2, 4, 0);
            @(negedge clk);
            digits2 = rnd2;
            play2   = 1'b1;
            for (int k = 1; k <= 11; k++) begin
                @(negedge clk);
                chk("nogap_rand", k, obs2(), exp_at(k - 1));
            end
            play2 = 1'b0;
            @(negedge clk);
            chk("nogap_rand_idle", 12, obs2(), zero_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
